// File: rtl/fmap_frame_buffer.sv
// Frame buffer between two conv layers: captures one H x W frame of packed channel
// beats, then replays it on start with optional idle cycles after each row.
module fmap_frame_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 32,
    parameter int WIDTH      = 28,
    parameter int HEIGHT     = 28,
    parameter int ROW_GAP    = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDTH*CHANNELS-1:0] i_data,
    input  logic                           valid_in,
    input  logic                           start,
    output logic [DATA_WIDTH*CHANNELS-1:0] o_data,
    output logic                           valid_out,
    output logic                           frame_ready,
    output logic                           busy,
    output logic                           overflow,
    output logic [15:0]                    frame_cnt
);
    localparam int BW    = DATA_WIDTH * CHANNELS;
    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic [1:0] {IDLE, FILL, FULL, DRAIN} state_t;

    state_t          state_reg;
    logic [AW-1:0]   wr_addr_reg;
    logic [AW-1:0]   rd_addr_reg;
    logic [CW-1:0]   col_reg;
    logic [RW-1:0]   row_reg;
    logic [3:0]      gap_reg;
    logic            last_reg;
    logic            valid_out_reg;
    logic            frame_ready_reg;
    logic            busy_reg;
    logic            overflow_reg;
    logic [15:0]     frame_cnt_reg;
    logic [BW-1:0]   rd_data_reg;
    logic [BW-1:0]   ram [DEPTH];

    logic            we;
    logic            rd_en;
    logic [AW-1:0]   ram_addr;

    // Writes and reads never overlap, so one shared address keeps the RAM single-port.
    always_comb begin
        we       = !rst && valid_in && (state_reg == IDLE || state_reg == FILL);
        rd_en    = !rst && (state_reg == DRAIN) && (gap_reg == 4'd0) && !last_reg;
        ram_addr = (state_reg == DRAIN) ? rd_addr_reg : wr_addr_reg;
    end

    always_ff @(posedge clk) begin
        if (we)
            ram[ram_addr] <= i_data;
        if (rst)
            rd_data_reg <= '0;
        else if (rd_en)
            rd_data_reg <= ram[ram_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            wr_addr_reg     <= '0;
            rd_addr_reg     <= '0;
            col_reg         <= '0;
            row_reg         <= '0;
            gap_reg         <= 4'd0;
            last_reg        <= 1'b0;
            valid_out_reg   <= 1'b0;
            frame_ready_reg <= 1'b0;
            busy_reg        <= 1'b0;
            overflow_reg    <= 1'b0;
            frame_cnt_reg   <= 16'd0;
        end else begin
            valid_out_reg <= rd_en;
            if (valid_in && (state_reg == FULL || state_reg == DRAIN))
                overflow_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (valid_in) begin
                        if (DEPTH == 1) begin
                            state_reg       <= FULL;
                            frame_ready_reg <= 1'b1;
                        end else begin
                            state_reg   <= FILL;
                            wr_addr_reg <= AW'(1);
                        end
                    end
                end
                FILL: begin
                    if (valid_in) begin
                        if (wr_addr_reg == AW'(DEPTH - 1)) begin
                            state_reg       <= FULL;
                            frame_ready_reg <= 1'b1;
                            wr_addr_reg     <= '0;
                        end else begin
                            wr_addr_reg <= wr_addr_reg + AW'(1);
                        end
                    end
                end
                FULL: begin
                    if (start) begin
                        state_reg       <= DRAIN;
                        frame_ready_reg <= 1'b0;
                        busy_reg        <= 1'b1;
                        rd_addr_reg     <= '0;
                        col_reg         <= '0;
                        row_reg         <= '0;
                        gap_reg         <= 4'd0;
                        last_reg        <= 1'b0;
                    end
                end
                DRAIN: begin
                    // One extra DRAIN cycle after the final read so busy drops with valid_out.
                    if (last_reg) begin
                        state_reg     <= IDLE;
                        busy_reg      <= 1'b0;
                        last_reg      <= 1'b0;
                        frame_cnt_reg <= frame_cnt_reg + 16'd1;
                    end else if (gap_reg != 4'd0) begin
                        gap_reg <= gap_reg - 4'd1;
                    end else begin
                        if (col_reg == CW'(WIDTH - 1)) begin
                            col_reg <= '0;
                            if (row_reg == RW'(HEIGHT - 1)) begin
                                last_reg <= 1'b1;
                            end else begin
                                row_reg <= row_reg + RW'(1);
                                gap_reg <= 4'(ROW_GAP);
                            end
                        end else begin
                            col_reg <= col_reg + CW'(1);
                        end
                        if (rd_addr_reg != AW'(DEPTH - 1))
                            rd_addr_reg <= rd_addr_reg + AW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_data      = rd_data_reg;
    assign valid_out   = valid_out_reg;
    assign frame_ready = frame_ready_reg;
    assign busy        = busy_reg;
    assign overflow    = overflow_reg;
    assign frame_cnt   = frame_cnt_reg;
endmodule

// File: tb/tb_fmap_frame_buffer.sv
// Scoreboard bench: two buffers (row gap 0 and 3) share stimulus; each output
// stream is popped against its own queue of expected beats.
module tb_fmap_frame_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i_data;
    logic        valid_in;
    logic        start;

    logic [15:0] a_o_data, b_o_data;
    logic        a_valid, b_valid, a_ready, b_ready, a_busy, b_busy, a_ovf, b_ovf;
    logic [15:0] a_fc, b_fc;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_fc = 0;

    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];

    int a_first = -1, a_last = -1, a_fall = -1, a_nvalid = 0;
    int b_first = -1, b_last = -1, b_fall = -1;
    logic [31:0] b_mask = 0;
    logic a_busy_prev = 1'b0, b_busy_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fmap_frame_buffer #(.DATA_WIDTH(8), .CHANNELS(2), .WIDTH(4), .HEIGHT(2), .ROW_GAP(0)) dut_a (
        .clk(clk), .rst(rst), .i_data(i_data), .valid_in(valid_in), .start(start),
        .o_data(a_o_data), .valid_out(a_valid), .frame_ready(a_ready), .busy(a_busy),
        .overflow(a_ovf), .frame_cnt(a_fc));

    fmap_frame_buffer #(.DATA_WIDTH(8), .CHANNELS(2), .WIDTH(4), .HEIGHT(2), .ROW_GAP(3)) dut_b (
        .clk(clk), .rst(rst), .i_data(i_data), .valid_in(valid_in), .start(start),
        .o_data(b_o_data), .valid_out(b_valid), .frame_ready(b_ready), .busy(b_busy),
        .overflow(b_ovf), .frame_cnt(b_fc));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected beats and records output timing per frame.
    always @(negedge clk) begin
        if (rst) begin
            exp_a.delete();
            exp_b.delete();
        end else begin
            if (start) begin
                a_first = -1; a_last = -1; a_fall = -1; a_nvalid = 0;
                b_first = -1; b_last = -1; b_fall = -1; b_mask = 0;
            end
            if (a_valid) begin
                if (exp_a.size() == 0) check("a_unexpected_beat", {16'd0, a_o_data}, 32'hFFFF_FFFF);
                else check("a_data", {16'd0, a_o_data}, {16'd0, exp_a.pop_front()});
                if (a_first < 0) a_first = cyc;
                a_last = cyc;
                a_nvalid++;
            end
            if (b_valid) begin
                if (exp_b.size() == 0) check("b_unexpected_beat", {16'd0, b_o_data}, 32'hFFFF_FFFF);
                else check("b_data", {16'd0, b_o_data}, {16'd0, exp_b.pop_front()});
                if (b_first < 0) b_first = cyc;
                b_last = cyc;
                if (cyc - b_first < 32) b_mask[cyc - b_first] = 1'b1;
            end
            if (a_busy_prev && !a_busy) a_fall = cyc;
            if (b_busy_prev && !b_busy) b_fall = cyc;
        end
        a_busy_prev = a_busy;
        b_busy_prev = b_busy;
    end

    function automatic logic [15:0] beat(input int i, input logic [15:0] x);
        return {8'(i + 1), 8'(i)} ^ x;
    endfunction

    task automatic fill(input logic [15:0] x, input bit bubbled);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            valid_in = 1'b1;
            i_data   = beat(i, x);
            exp_a.push_back(beat(i, x));
            exp_b.push_back(beat(i, x));
            if (bubbled) begin
                @(posedge clk); #1;
                valid_in = 1'b0;
                @(negedge clk);
                check($sformatf("frame_ready_after_beat%0d", i), {31'd0, a_ready}, {31'd0, i == 7});
            end
        end
        if (!bubbled) begin
            @(posedge clk); #1;
            valid_in = 1'b0;
            @(negedge clk);
            check("frame_ready_after_fill", {31'd0, a_ready}, 32'd1);
        end
    endtask

    task automatic drain(input bit vin);
        int  st;
        bit  done;
        @(posedge clk); #1;
        start = 1'b1;
        st = cyc;
        if (vin) begin valid_in = 1'b1; i_data = 16'hFFFF; end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("drain_busy_high", {30'd0, a_busy, b_busy}, 32'd3);
        check("drain_ready_low", {30'd0, a_ready, b_ready}, 32'd0);
        if (vin) begin
            repeat (2) @(posedge clk);
            #1 valid_in = 1'b0;
        end
        done = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!a_busy && !b_busy && exp_a.size() == 0 && exp_b.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_completes", {31'd0, done}, 32'd1);
        @(negedge clk);
        exp_fc++;
        check("a_latency", a_first - st, 32'd2);
        check("b_latency", b_first - st, 32'd2);
        check("a_span", a_last - a_first + 1, 32'd8);
        check("b_span", b_last - b_first + 1, 32'd11);
        check("b_gap_pattern", b_mask, 32'h78F);
        check("a_busy_fall", a_fall, a_last + 1);
        check("b_busy_fall", b_fall, b_last + 1);
        check("a_frame_cnt", {16'd0, a_fc}, exp_fc);
        check("b_frame_cnt", {16'd0, b_fc}, exp_fc);
    endtask

    initial begin
        bit got3;
        rst = 1'b1; valid_in = 1'b0; start = 1'b0; i_data = 16'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_valid_out", {31'd0, a_valid}, 32'd0);
        check("reset_busy", {31'd0, a_busy}, 32'd0);
        check("reset_frame_ready", {31'd0, a_ready}, 32'd0);
        check("reset_overflow", {31'd0, a_ovf}, 32'd0);
        check("reset_frame_cnt", {16'd0, a_fc}, 32'd0);
        check("reset_o_data", {16'd0, a_o_data}, 32'd0);

        // start while idle must be ignored
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("idle_start_no_output", {29'd0, a_valid, b_valid, a_busy | b_busy}, 32'd0);
        end

        fill(16'h0000, 1'b0);
        drain(1'b0);
        $display("frame 1 contiguous fill: frame_cnt=%0d", a_fc);

        fill(16'h5A30, 1'b1);
        drain(1'b0);
        $display("frame 2 bubbled fill: frame_cnt=%0d", a_fc);

        fill(16'hC3C0, 1'b0);
        @(posedge clk); #1 valid_in = 1'b1; i_data = 16'hFFFF;
        @(posedge clk); #1 valid_in = 1'b0;
        @(negedge clk);
        check("overflow_in_full", {30'd0, a_ovf, b_ovf}, 32'd3);
        check("ready_after_drop", {31'd0, a_ready}, 32'd1);
        drain(1'b1);
        check("overflow_sticky", {30'd0, a_ovf, b_ovf}, 32'd3);
        check("idle_after_overflow_drain", {31'd0, a_ready}, 32'd0);
        $display("frame 3 overflow: overflow=%0d frame_cnt=%0d", a_ovf, a_fc);

        fill(16'h0F00, 1'b0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        got3 = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            if (a_nvalid >= 3) begin got3 = 1'b1; break; end
        end
        check("third_beat_seen", {31'd0, got3}, 32'd1);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid_out", {30'd0, a_valid, b_valid}, 32'd0);
        check("rst_mid_busy", {30'd0, a_busy, b_busy}, 32'd0);
        check("rst_mid_frame_cnt", {16'd0, a_fc}, 32'd0);
        check("rst_mid_frame_ready", {31'd0, a_ready}, 32'd0);
        check("rst_mid_overflow", {31'd0, a_ovf}, 32'd0);
        exp_fc = 0;
        $display("reset mid-drain: valid_out=%0d busy=%0d", a_valid, a_busy);

        fill(16'h2220, 1'b0);
        drain(1'b0);
        $display("frame after reset: frame_cnt=%0d", a_fc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fmap_frame_buffer.md
Name: fmap_frame_buffer

Overview:
Parametrised feature-map frame buffer that sits between two VGG16 conv layers.
- Captures one full H x W frame of multi-channel pixels from the upstream layer's valid_in stream.
- Replays the frame to the downstream layer on a start pulse, with optional idle gap cycles after each row for downstream line buffers.
- Replaces ad-hoc capture RAMs: adds frame-complete signalling, overflow detection, a frame counter and gated replay.

Parameters:
- DATA_WIDTH, 32, bits per channel sample.
- CHANNELS, 32, channels packed per beat; beat width = DATA_WIDTH*CHANNELS.
- WIDTH, 28, pixels per row.
- HEIGHT, 28, rows per frame; DEPTH = WIDTH*HEIGHT beats.
- ROW_GAP, 0, idle cycles inserted after each row during drain (0..15).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- i_data  in  DATA_WIDTH*CHANNELS  input pixel beat; channel 0 in LSBs.
- valid_in  in  1  i_data valid this cycle.
- start  in  1  single-cycle pulse; begins replay when frame_ready=1.
- o_data  out  DATA_WIDTH*CHANNELS  replayed pixel beat.
- valid_out  out  1  o_data valid this cycle.
- frame_ready  out  1  full frame stored, awaiting start.
- busy  out  1  high in DRAIN.
- overflow  out  1  sticky: a beat was dropped.
- frame_cnt  out  16  frames fully drained, wraps at 2^16.

Behaviour:
- Reset (rst=1 at clk edge):
  - State goes to IDLE; write/read address, row counters and gap counters go to 0.
  - valid_out=0, frame_ready=0, busy=0, overflow=0, frame_cnt=0; o_data goes to 0.
  - RAM contents are not cleared.
  - Reset mid-fill or mid-drain aborts immediately; no further valid_out.
- States: IDLE, FILL, FULL, DRAIN.
- IDLE:
  - valid_in=1 writes i_data to addr 0, wr_addr becomes 1, state goes to FILL.
  - If DEPTH==1, goes straight to FULL.
- FILL:
  - Each valid_in=1 writes to wr_addr and increments it.
  - The write of beat DEPTH-1 moves the state to FULL; frame_ready=1 from the next cycle.
  - Bubbles (valid_in=0) are allowed and hold wr_addr.
- FULL:
  - frame_ready=1.
  - valid_in=1 drops the beat and sets overflow; RAM is unchanged.
  - start=1 moves to DRAIN next cycle, with rd_addr=0 and frame_ready=0.
  - start in any other state is ignored.
- DRAIN:
  - busy=1. RAM read is registered: valid_out rises exactly 2 cycles after the start cycle (1 cycle to enter DRAIN, 1 cycle read latency).
  - One beat per cycle, in write order, except after each row's last beat (col==WIDTH-1): ROW_GAP cycles with valid_out=0 and rd_addr held.
  - No gap after the final row.
  - After beat DEPTH-1 is output: state returns to IDLE, frame_cnt increments, busy=0 on the same edge that drops valid_out.
  - valid_in during DRAIN is dropped and sets overflow.
- Simultaneous events:
  - valid_in on the cycle the state moves DRAIN to IDLE is dropped (overflow set).
  - valid_in on the same cycle start is accepted in FULL is dropped (overflow set).
- overflow clears only on rst.
- o_data holds its last value while valid_out=0.
- Total valid_out count per frame = DEPTH exactly.
- Drain duration from first to last valid_out = DEPTH + (HEIGHT-1)*ROW_GAP cycles.
- RAM: single-port inferred block RAM, DEPTH x (DATA_WIDTH*CHANNELS). Address width is $clog2(DEPTH).

Test Plan:
Bench parameters: DATA_WIDTH=8, CHANNELS=2, WIDTH=4, HEIGHT=2.
- Basic fill/drain, ROW_GAP=0:
  - Stimulus: write 8 beats 16'h0100..16'h0807 contiguously, then pulse start.
  - Required: frame_ready=1 one cycle after the 8th write. valid_out rises 2 cycles after start, with 8 consecutive beats 16'h0100..16'h0807. busy falls with the last beat; frame_cnt=1.
- Bubbled input:
  - Stimulus: same 8 beats with valid_in toggling 1/0.
  - Required: identical drained sequence; frame_ready only after the 8th accepted beat.
- Row gap, ROW_GAP=3:
  - Required: beats 0-3, then 3 cycles valid_out=0, then beats 4-7; 11 cycles first to last valid_out; no gap after beat 7.
- Overflow:
  - Stimulus: in FULL, assert valid_in with 16'hFFFF; during DRAIN assert valid_in again.
  - Required: overflow=1 and stays 1. The drained data does not contain 16'hFFFF.
- Reset mid-drain:
  - Stimulus: assert rst after the 3rd valid_out.
  - Required: next cycle valid_out=0, busy=0, frame_cnt=0, state IDLE. A fresh 8-beat fill and drain then works correctly.
- Back-to-back frames and ignored start:
  - Stimulus: start pulse in IDLE; then fill, drain, fill, drain.
  - Required: the IDLE start produces no output; frame_cnt=2; the second frame's data is correct.
